// File: rtl/dm_responder.sv
// Data-memory responder: accepts one M-stage request, waits LATENCY cycles, then commits the store or returns extended load data.
// Optional alignment/range checking is enabled by defining DM_ALIGN_CHECK_EN.
module dm_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic [2:0]  req_dexop,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = 4;
`ifdef DM_ALIGN_CHECK_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [31:0]        addr_r, wdata_r;
    logic [3:0]         be_r;
    logic               we_r;
    logic [2:0]         dexop_r;
    logic               accept_s, access_s, err_s, wr_en_s;
    logic [ADDR_W-1:0]  idx_s;
    logic [31:0]        rd_word_s, lane_data_s, rdata_s;
    logic [31:0]        mem [DEPTH];

    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: be_legal = 1'b1;
            default:                            be_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [3:0] be, input logic [31:0] wdata);
        case (be)
            4'b1111:                            lane_data = wdata;
            4'b0011, 4'b1100:                   lane_data = {2{wdata[15:0]}};
            4'b0001, 4'b0010, 4'b0100, 4'b1000: lane_data = {4{wdata[7:0]}};
            default:                            lane_data = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] off,
                                                input logic [2:0] dexop);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (dexop)
            3'b001:  extend_load = {24'h000000, b};
            3'b010:  extend_load = {{24{b[7]}}, b};
            3'b011:  extend_load = {16'h0000, h};
            3'b100:  extend_load = {{16{h[15]}}, h};
            default: extend_load = word;
        endcase
    endfunction

    // Stores are sized by BE, loads by DEXop; any address bit beyond the array is a range fault.
    function automatic logic align_fault(input logic [31:0] addr, input logic [3:0] be,
                                         input logic we, input logic [2:0] dexop);
        logic fault;
        if (we) begin
            case (be)
                4'b1111: fault = (addr[1:0] != 2'b00);
                4'b0011: fault = (addr[1:0] != 2'b00);
                4'b1100: fault = (addr[1:0] != 2'b10);
                4'b0001: fault = (addr[1:0] != 2'b00);
                4'b0010: fault = (addr[1:0] != 2'b01);
                4'b0100: fault = (addr[1:0] != 2'b10);
                4'b1000: fault = (addr[1:0] != 2'b11);
                default: fault = 1'b1;
            endcase
        end else begin
            case (dexop)
                3'b001, 3'b010: fault = 1'b0;
                3'b011, 3'b100: fault = addr[0];
                default:        fault = (addr[1:0] != 2'b00);
            endcase
        end
        align_fault = fault | ((addr >> (ADDR_W + 2)) != 32'h0000_0000);
    endfunction

    assign req_ready = (state_r == IDLE);
    assign stall     = req_valid && (state_r != RESP);

    // Next-state, access strobe and response data
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        accept_s    = 1'b0;
        access_s    = 1'b0;
        idx_s       = addr_r[ADDR_W+1:2];
        rd_word_s   = mem[idx_s];
        lane_data_s = lane_data(be_r, wdata_r);
        err_s       = ALIGN_EN && align_fault(addr_r, be_r, we_r, dexop_r);
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    cnt_s    = CNT_W'(LATENCY - 1);
                    state_s  = WAIT;
                end else begin
                    state_s  = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_s    = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    access_s = 1'b1;
                    state_s  = RESP;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        wr_en_s = access_s && we_r && be_legal(be_r) && !err_s;
        if (we_r || err_s) begin
            rdata_s = 32'h0000_0000;
        end else begin
            rdata_s = extend_load(rd_word_s, addr_r[1:0], dexop_r);
        end
    end

    // FSM, request latch and registered response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            be_r       <= 4'b0000;
            we_r       <= 1'b0;
            dexop_r    <= 3'b000;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            resp_err   <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            if (accept_s) begin
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                be_r    <= req_be;
                we_r    <= req_we;
                dexop_r <= req_dexop;
            end
            resp_valid <= access_s;
            resp_rdata <= access_s ? rdata_s : 32'h0000_0000;
            resp_err   <= access_s ? err_s : 1'b0;
        end
    end

    // Byte-lane masked store on the access edge; the array itself is never reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_r[i]) begin
                    mem[idx_s][8*i +: 8] <= lane_data_s[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed scenarios plus randomized requests against a word-array reference model.
module tb_dm_responder;

    localparam int LAT    = 2;
    localparam int AW     = 10;
    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic [2:0]  req_dexop = 3'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model_mem [0:(1<<AW)-1];

    dm_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_dexop(req_dexop),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall)
    );

    always #(PERIOD/2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] dexop);
        logic [31:0] b, h;
        b = (word >> (8 * off)) & 32'h0000_00FF;
        h = (word >> (16 * (off / 2))) & 32'h0000_FFFF;
        case (dexop)
            3'd1:    return b;
            3'd2:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd3:    return h;
            3'd4:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [3:0] be,
                                              input logic [31:0] wdata);
        logic [31:0] res, b;
        int kind;
        res = old;
        if (be == 4'b1111) kind = 4;
        else if (be == 4'b0011 || be == 4'b1100) kind = 2;
        else if (be == 4'b0001 || be == 4'b0010 || be == 4'b0100 || be == 4'b1000) kind = 1;
        else kind = 0;
        if (kind == 0) return old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                if (kind == 1)      b = wdata & 32'hFF;
                else if (kind == 2) b = (wdata >> (8 * (i % 2))) & 32'hFF;
                else                b = (wdata >> (8 * i)) & 32'hFF;
                res = (res & ~(32'hFF << (8 * i))) | (b << (8 * i));
            end
        end
        return res;
    endfunction

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [2:0] dexop, input bit keep,
                          output logic [31:0] rdata_seen, output longint t_acc);
        logic [31:0] exp_rdata;
        int idx, n;
        bit seen;
        @(negedge clk);
        check("idle_valid", {31'h0, resp_valid}, 32'd0);
        check("idle_rdata", resp_rdata, 32'd0);
        check("idle_ready", {31'h0, req_ready}, 32'd1);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_dexop = dexop;
        req_valid = 1'b1;
        #1;
        check("idle_stall", {31'h0, stall}, 32'd1);
        idx = int'((addr >> 2) & ((1 << AW) - 1));
        if (we) begin
            exp_rdata = 32'd0;
            model_mem[idx] = ref_store(model_mem[idx], be, wdata);
        end else begin
            exp_rdata = ref_load(model_mem[idx], addr[1:0], dexop);
        end
        @(posedge clk);
        t_acc = $time;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 4 * (LAT + 2)) begin
            @(negedge clk);
            n++;
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                check("wait_ready", {31'h0, req_ready}, 32'd0);
                check("wait_stall", {31'h0, stall}, 32'd1);
                req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
                req_dexop = 3'($urandom); req_we = 1'($urandom);
            end
        end
        check("latency", n, LAT + 1);
        check("rdata", resp_rdata, exp_rdata);
        check("err", {31'h0, resp_err}, 32'd0);
        check("resp_stall", {31'h0, stall}, 32'd0);
        check("resp_ready", {31'h0, req_ready}, 32'd0);
        rdata_seen = resp_rdata;
        if (!keep) req_valid = 1'b0;
    endtask

    initial begin
        #(PERIOD * 50000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        longint t0, t1, t2;
        logic [3:0] legal_be [7];
        legal_be = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < (1 << AW); i++) model_mem[i] = 32'd0;

        #1 reset = 1'b1;
        #1;
        check("rst_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'h0, resp_err}, 32'd0);
        check("rst_ready", {31'h0, req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Clear the words the test touches so expectations do not depend on power-up contents
        for (int w = 0; w < 16; w++) do_req(1'b1, 32'(w * 4), 32'd0, 4'b1111, 3'd0, 1'b0, rd, t0);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 3'd0, 1'b0, rd, t0);
        do_req(1'b0, 32'h10, 32'h0, 4'b1111, 3'd0, 1'b0, rd, t0);
        check("lw_10", rd, 32'hDEADBEEF);

        do_req(1'b1, 32'h13, 32'h00000080, 4'b1000, 3'd0, 1'b0, rd, t0);
        do_req(1'b0, 32'h13, 32'h0, 4'b1000, 3'd2, 1'b0, rd, t0);
        check("lb_13", rd, 32'hFFFFFF80);
        do_req(1'b0, 32'h13, 32'h0, 4'b1000, 3'd1, 1'b0, rd, t0);
        check("lbu_13", rd, 32'h00000080);
        do_req(1'b0, 32'h10, 32'h0, 4'b1111, 3'd0, 1'b0, rd, t0);
        check("lw_10_b", rd, 32'h80ADBEEF);

        do_req(1'b1, 32'h22, 32'h00008001, 4'b1100, 3'd0, 1'b0, rd, t0);
        do_req(1'b0, 32'h22, 32'h0, 4'b1100, 3'd4, 1'b0, rd, t0);
        check("lh_22", rd, 32'hFFFF8001);
        do_req(1'b0, 32'h22, 32'h0, 4'b1100, 3'd3, 1'b0, rd, t0);
        check("lhu_22", rd, 32'h00008001);
        do_req(1'b0, 32'h20, 32'h0, 4'b0011, 3'd4, 1'b0, rd, t0);
        check("lh_20", rd, 32'h00000000);

        do_req(1'b1, 32'h2000, 32'h12345678, 4'b1111, 3'd0, 1'b0, rd, t0);
        do_req(1'b0, 32'h0, 32'h0, 4'b1111, 3'd0, 1'b0, rd, t0);
        check("alias_w0", rd, 32'h12345678);

        do_req(1'b1, 32'h30, 32'hFFFFFFFF, 4'b0101, 3'd0, 1'b0, rd, t0);
        do_req(1'b0, 32'h30, 32'h0, 4'b1111, 3'd0, 1'b0, rd, t0);
        check("illegal_be", rd, 32'h00000000);

        do_req(1'b0, 32'h10, 32'h0, 4'b1111, 3'd0, 1'b1, rd, t0);
        do_req(1'b0, 32'h00, 32'h0, 4'b1111, 3'd0, 1'b1, rd, t1);
        do_req(1'b0, 32'h20, 32'h0, 4'b1111, 3'd0, 1'b0, rd, t2);
        check("spacing_1", 32'(t1 - t0), 32'((LAT + 2) * PERIOD));
        check("spacing_2", 32'(t2 - t1), 32'((LAT + 2) * PERIOD));

        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h11111111; req_be = 4'b1111;
        req_dexop = 3'd0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'h0, resp_valid}, 32'd0);
        check("mid_rst_rdata", resp_rdata, 32'd0);
        check("mid_rst_err", {31'h0, resp_err}, 32'd0);
        check("mid_rst_ready", {31'h0, req_ready}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk) reset = 1'b0;
        repeat (LAT + 3) begin
            @(negedge clk);
            check("post_rst_valid", {31'h0, resp_valid}, 32'd0);
            check("post_rst_ready", {31'h0, req_ready}, 32'd1);
        end
        do_req(1'b0, 32'h10, 32'h0, 4'b1111, 3'd0, 1'b0, rd, t0);
        check("rst_drop", rd, 32'h80ADBEEF);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            logic [3:0]  be;
            a = 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom << (AW + 2));
            be = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal_be[$urandom_range(0, 6)];
            do_req(1'($urandom), a, $urandom, be, 3'($urandom), bit'($urandom_range(0, 1)), rd, t0);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
